// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the integer pipeline blocks.
//   XLEN       - integer datapath width
//   REG_IDX_W  - architectural register index width
//   LU_DEPTH   - default depth of the long-latency unit result buffer
//   PC_W       - program counter width
//   rf_wr_t    - one register-file write request {rd, wen, data}
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int LU_DEPTH  = 2;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 wen;
        logic [XLEN-1:0]      data;
    } rf_wr_t;

    // One-hot decode of a register index into a 32-bit pend-style mask.
    function automatic logic [31:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a synchronous active-high reset.
//   clk, rst          - clock and synchronous reset (empties the FIFO)
//   push, push_data   - write request (ignored when full)
//   pop               - read request (ignored when empty)
//   pop_data          - head entry, valid whenever empty is low
//   full, empty       - occupancy flags derived from an extra count bit
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the occupancy flags.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_r <= do_push_s ? wr_ptr_r + AW'(1'b1) : wr_ptr_r;
            rd_ptr_r <= do_pop_s  ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == (AW+1)'(DEPTH));
    assign empty    = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: shares the single integer register-file write port between
// the writeback stage (always wins, never stalls) and the long-latency unit,
// whose results wait in a small FIFO. A scoreboard of in-flight LU
// destinations drives the decode-stage stall.
//   clk, rst                           - clock, synchronous active-high reset
//   ws_valid/ws_rd/ws_wen/ws_data/ws_pc - writeback stage write request
//   lu_valid/lu_ready/lu_rd/lu_data/lu_pc - LU result handshake
//   ds_*                               - decode-stage hazard query and LU issue
//   ds_stall                           - hazard against a pending LU destination
//   rf_we/rf_waddr/rf_wdata            - register-file write port
//   debug_wb_*                         - trace of the write performed this cycle
//   contention_cnt                     - saturating count of LU-head wait cycles
module rf_wport_arb #(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int LU_DEPTH = riscv_pkg::LU_DEPTH,
    parameter int SAT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ws_valid,
    input  logic [riscv_pkg::REG_IDX_W-1:0] ws_rd,
    input  logic                            ws_wen,
    input  logic [XLEN-1:0]                 ws_data,
    input  logic [31:0]                     ws_pc,
    input  logic                            lu_valid,
    output logic                            lu_ready,
    input  logic [riscv_pkg::REG_IDX_W-1:0] lu_rd,
    input  logic [XLEN-1:0]                 lu_data,
    input  logic [31:0]                     lu_pc,
    input  logic                            ds_valid,
    input  logic [riscv_pkg::REG_IDX_W-1:0] ds_rs1,
    input  logic [riscv_pkg::REG_IDX_W-1:0] ds_rs2,
    input  logic [riscv_pkg::REG_IDX_W-1:0] ds_rd,
    input  logic                            ds_rs1_use,
    input  logic                            ds_rs2_use,
    input  logic                            ds_rd_wen,
    input  logic                            ds_lu_issue,
    output logic                            ds_stall,
    output logic                            rf_we,
    output logic [riscv_pkg::REG_IDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]                 rf_wdata,
    output logic [31:0]                     debug_wb_pc,
    output logic [3:0]                      debug_wb_rf_wen,
    output logic [4:0]                      debug_wb_rf_wnum,
    output logic [31:0]                     debug_wb_rf_wdata,
    output logic [SAT_W-1:0]                contention_cnt
);

    import riscv_pkg::*;

    localparam int ENTRY_W = REG_IDX_W + XLEN + 32;

    logic                 wb_busy_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ENTRY_W-1:0]   head_s;
    logic [REG_IDX_W-1:0] head_rd_s;
    logic [XLEN-1:0]      head_data_s;
    logic [31:0]          head_pc_s;
    logic [31:0]          pend_r;
    logic [31:0]          pend_nxt_s;
    logic [31:0]          set_vec_s;
    logic [31:0]          clr_vec_s;
    logic [SAT_W-1:0]     cnt_r;
    rf_wr_t               sel_s;
    logic [31:0]          sel_pc_s;

    assign wb_busy_s = ws_valid && ws_wen && (ws_rd != {REG_IDX_W{1'b0}});
    assign lu_ready  = !fifo_full_s && !rst;
    // Results to x0 are acknowledged but never occupy a slot.
    assign push_s    = lu_valid && lu_ready && (lu_rd != {REG_IDX_W{1'b0}});
    // The head is written (and popped) in any cycle WB leaves the port free.
    assign pop_s     = !rst && !fifo_empty_s && !wb_busy_s;

    sync_fifo #(
        .DEPTH (LU_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_lu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({lu_rd, lu_data, lu_pc}),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign head_pc_s   = head_s[31:0];
    assign head_data_s = head_s[32 +: XLEN];
    assign head_rd_s   = head_s[32 + XLEN +: REG_IDX_W];

    // Scoreboard update: issue sets, LU writeback clears, set wins on a tie.
    always_comb begin
        set_vec_s  = (ds_lu_issue && (ds_rd != {REG_IDX_W{1'b0}})) ? reg_onehot(ds_rd) : 32'd0;
        clr_vec_s  = pop_s ? reg_onehot(head_rd_s) : 32'd0;
        pend_nxt_s = ((pend_r & ~clr_vec_s) | set_vec_s) & 32'hFFFF_FFFE;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Decode hazard check against registered pend only.
    always_comb begin
        if (rst) begin
            ds_stall = 1'b0;
        end else begin
            ds_stall = ds_valid && ((ds_rs1_use && pend_r[ds_rs1]) ||
                                    (ds_rs2_use && pend_r[ds_rs2]) ||
                                    (ds_rd_wen  && pend_r[ds_rd]));
        end
    end

    // Saturating count of cycles the LU head lost the port to WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {SAT_W{1'b0}};
        end else if (!fifo_empty_s && wb_busy_s && (cnt_r != {SAT_W{1'b1}})) begin
            cnt_r <= cnt_r + SAT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign contention_cnt = cnt_r;

    // Write-port source select: WB first, then the FIFO head, else idle zeros.
    always_comb begin
        sel_s    = '{rd: {REG_IDX_W{1'b0}}, wen: 1'b0, data: {riscv_pkg::XLEN{1'b0}}};
        sel_pc_s = 32'd0;
        if (rst) begin
            sel_s.wen = 1'b0;
        end else if (wb_busy_s) begin
            sel_s    = '{rd: ws_rd, wen: 1'b1, data: ws_data};
            sel_pc_s = ws_pc;
        end else if (!fifo_empty_s) begin
            sel_s    = '{rd: head_rd_s, wen: 1'b1, data: head_data_s};
            sel_pc_s = head_pc_s;
        end else begin
            sel_s.wen = 1'b0;
        end
    end

    assign rf_we             = sel_s.wen;
    assign rf_waddr          = sel_s.rd;
    assign rf_wdata          = sel_s.data;
    assign debug_wb_pc       = sel_pc_s;
    assign debug_wb_rf_wen   = {4{sel_s.wen}};
    assign debug_wb_rf_wnum  = sel_s.rd;
    assign debug_wb_rf_wdata = sel_s.data;

endmodule

// File: tb/tb_rf_wport_arb.sv
// tb_rf_wport_arb: directed vector table for the WB pass-through path plus
// hand-written sequences for LU latency, contention, hazards and reset.
module tb_rf_wport_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ws_valid, ws_wen;
    logic [4:0]  ws_rd;
    logic [31:0] ws_data, ws_pc;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data, lu_pc;
    logic        ds_valid, ds_rs1_use, ds_rs2_use, ds_rd_wen, ds_lu_issue, ds_stall;
    logic [4:0]  ds_rs1, ds_rs2, ds_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [15:0] contention_cnt;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        ws_valid;
        logic        ws_wen;
        logic [4:0]  ws_rd;
        logic [31:0] ws_data;
        logic [31:0] ws_pc;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    rf_wport_arb dut (
        .clk               (clk),
        .rst               (rst),
        .ws_valid          (ws_valid),
        .ws_rd             (ws_rd),
        .ws_wen            (ws_wen),
        .ws_data           (ws_data),
        .ws_pc             (ws_pc),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_rd             (lu_rd),
        .lu_data           (lu_data),
        .lu_pc             (lu_pc),
        .ds_valid          (ds_valid),
        .ds_rs1            (ds_rs1),
        .ds_rs2            (ds_rs2),
        .ds_rd             (ds_rd),
        .ds_rs1_use        (ds_rs1_use),
        .ds_rs2_use        (ds_rs2_use),
        .ds_rd_wen         (ds_rd_wen),
        .ds_lu_issue       (ds_lu_issue),
        .ds_stall          (ds_stall),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .contention_cnt    (contention_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ws_valid = 1'b0; ws_wen = 1'b0; ws_rd = 5'd0; ws_data = 32'd0; ws_pc = 32'd0;
        lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0; lu_pc = 32'd0;
        ds_valid = 1'b0; ds_rs1 = 5'd0; ds_rs2 = 5'd0; ds_rd = 5'd0;
        ds_rs1_use = 1'b0; ds_rs2_use = 1'b0; ds_rd_wen = 1'b0; ds_lu_issue = 1'b0;
    endtask

    // Advance to just after the next rising edge and clear all inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        ws_valid = 1'b1; ws_wen = 1'b1; ws_rd = rd; ws_data = data; ws_pc = 32'h1000 + {27'd0, rd};
    endtask

    task automatic lu(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        lu_valid = 1'b1; lu_rd = rd; lu_data = data; lu_pc = pc;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  32'h0000_1234, 32'h0000_0100, 1'b1, 5'd5,  32'h0000_1234, 32'h0000_0100};
        vecs[1] = '{1'b1, 1'b1, 5'd0,  32'h0000_5555, 32'h0000_0104, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b1, 5'd5,  32'h0000_6666, 32'h0000_0108, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b0, 5'd5,  32'h0000_7777, 32'h0000_010C, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0110, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0110};

        // Reset: outputs forced low while rst is high, even with WB busy.
        idle();
        rst = 1'b1;
        wb(5'd5, 32'h0000_1234);
        ds_valid = 1'b1; ds_rs1 = 5'd7; ds_rs1_use = 1'b1;
        @(posedge clk); #1;
        wb(5'd5, 32'h0000_1234);
        #1;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_lu_ready", lu_ready, 1'b0);
        chk("rst_ds_stall", ds_stall, 1'b0);
        chk("rst_dbg_wen", debug_wb_rf_wen, 4'h0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        chk("rst_cnt", contention_cnt, 16'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_lu_ready", lu_ready, 1'b1);
        chk("post_rst_rf_we", rf_we, 1'b0);

        // WB pass-through table, FIFO empty.
        for (int i = 0; i < 5; i++) begin
            cyc();
            ws_valid = vecs[i].ws_valid; ws_wen = vecs[i].ws_wen; ws_rd = vecs[i].ws_rd;
            ws_data = vecs[i].ws_data; ws_pc = vecs[i].ws_pc;
            #1;
            chk($sformatf("vec%0d_we", i), rf_we, vecs[i].exp_we);
            chk($sformatf("vec%0d_addr", i), rf_waddr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_data", i), rf_wdata, vecs[i].exp_data);
            chk($sformatf("vec%0d_dbg_pc", i), debug_wb_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_dbg_wen", i), debug_wb_rf_wen, {4{vecs[i].exp_we}});
            chk($sformatf("vec%0d_dbg_wdata", i), debug_wb_rf_wdata, vecs[i].exp_data);
        end

        // LU alone: issue x7, result at N, write at N+1, stall clears at N+2.
        cyc();
        ds_valid = 1'b1; ds_rd = 5'd7; ds_rd_wen = 1'b1; ds_lu_issue = 1'b1;
        #1;
        chk("lu_issue_nostall", ds_stall, 1'b0);
        cyc();
        lu(5'd7, 32'h0000_CAFE, 32'h0000_0200);
        ds_valid = 1'b1; ds_rs1 = 5'd7; ds_rs1_use = 1'b1;
        #1;
        chk("lu_n_stall", ds_stall, 1'b1);
        chk("lu_n_no_comb_write", rf_we, 1'b0);
        chk("lu_n_ready", lu_ready, 1'b1);
        cyc();
        ds_valid = 1'b1; ds_rs1 = 5'd7; ds_rs1_use = 1'b1;
        #1;
        chk("lu_n1_we", rf_we, 1'b1);
        chk("lu_n1_addr", rf_waddr, 5'd7);
        chk("lu_n1_data", rf_wdata, 32'h0000_CAFE);
        chk("lu_n1_dbg_pc", debug_wb_pc, 32'h0000_0200);
        chk("lu_n1_stall", ds_stall, 1'b1);
        cyc();
        ds_valid = 1'b1; ds_rs1 = 5'd7; ds_rs1_use = 1'b1;
        #1;
        chk("lu_n2_stall", ds_stall, 1'b0);
        chk("lu_n2_we", rf_we, 1'b0);

        // Contention: WB busy 4 cycles while LU pushes two results.
        cyc(); wb(5'd3, 32'h0000_00A0); lu(5'd10, 32'h0000_1010, 32'h0000_0300); #1;
        chk("ct0_ready", lu_ready, 1'b1);
        chk("ct0_addr", rf_waddr, 5'd3);
        chk("ct0_data", rf_wdata, 32'h0000_00A0);
        cyc(); wb(5'd4, 32'h0000_00A1); lu(5'd11, 32'h0000_1111, 32'h0000_0304); #1;
        chk("ct1_ready", lu_ready, 1'b1);
        chk("ct1_addr", rf_waddr, 5'd4);
        chk("ct1_cnt", contention_cnt, 16'd0);
        cyc(); wb(5'd5, 32'h0000_00A2); lu(5'd12, 32'h0000_1212, 32'h0000_0308); #1;
        chk("ct2_ready_full", lu_ready, 1'b0);
        chk("ct2_addr", rf_waddr, 5'd5);
        chk("ct2_cnt", contention_cnt, 16'd1);
        cyc(); wb(5'd6, 32'h0000_00A3); lu(5'd12, 32'h0000_1212, 32'h0000_0308); #1;
        chk("ct3_ready_full", lu_ready, 1'b0);
        chk("ct3_data", rf_wdata, 32'h0000_00A3);
        chk("ct3_cnt", contention_cnt, 16'd2);
        cyc(); #1;
        chk("ct4_we", rf_we, 1'b1);
        chk("ct4_addr", rf_waddr, 5'd10);
        chk("ct4_data", rf_wdata, 32'h0000_1010);
        chk("ct4_dbg_pc", debug_wb_pc, 32'h0000_0300);
        chk("ct4_cnt", contention_cnt, 16'd3);
        chk("ct4_ready", lu_ready, 1'b0);
        cyc(); #1;
        chk("ct5_addr", rf_waddr, 5'd11);
        chk("ct5_data", rf_wdata, 32'h0000_1111);
        chk("ct5_ready", lu_ready, 1'b1);
        cyc(); #1;
        chk("ct6_we", rf_we, 1'b0);
        chk("ct6_cnt", contention_cnt, 16'd3);

        // Hazards against pending x9.
        cyc();
        ds_valid = 1'b1; ds_rd = 5'd9; ds_rd_wen = 1'b1; ds_lu_issue = 1'b1;
        #1;
        cyc();
        ds_valid = 1'b1; ds_rs2 = 5'd9; ds_rs2_use = 1'b1; #1;
        chk("hz_rs2_used", ds_stall, 1'b1);
        ds_rs2_use = 1'b0; #1;
        chk("hz_rs2_unused", ds_stall, 1'b0);
        ds_rd = 5'd9; ds_rd_wen = 1'b1; #1;
        chk("hz_waw", ds_stall, 1'b1);
        ds_rd_wen = 1'b0; #1;
        chk("hz_rd_nowen", ds_stall, 1'b0);
        ds_valid = 1'b0; ds_rs2_use = 1'b1; #1;
        chk("hz_ds_invalid", ds_stall, 1'b0);
        cyc();
        ds_valid = 1'b1; ds_rd = 5'd0; ds_rd_wen = 1'b1; ds_lu_issue = 1'b1; #1;
        chk("hz_x0_issue", ds_stall, 1'b0);
        cyc();
        ds_valid = 1'b1; ds_rs1 = 5'd0; ds_rs1_use = 1'b1; ds_rd = 5'd0; ds_rd_wen = 1'b1; #1;
        chk("hz_x0_nopend", ds_stall, 1'b0);

        // LU result to x0: accepted, never written, occupies no slot.
        cyc(); lu(5'd0, 32'h0000_DEAD, 32'h0000_0400); #1;
        chk("x0_ready", lu_ready, 1'b1);
        cyc(); #1;
        chk("x0_no_write", rf_we, 1'b0);
        cyc(); wb(5'd1, 32'h0000_00B1); lu(5'd13, 32'h0000_1313, 32'h0000_0500);
        ds_valid = 1'b1; ds_rd = 5'd20; ds_lu_issue = 1'b1; #1;
        chk("x0_fill1_ready", lu_ready, 1'b1);
        cyc(); wb(5'd2, 32'h0000_00B2); lu(5'd14, 32'h0000_1414, 32'h0000_0504); #1;
        chk("x0_fill2_ready", lu_ready, 1'b1);
        cyc(); wb(5'd3, 32'h0000_00B3);
        ds_valid = 1'b1; ds_rs2 = 5'd9; ds_rs2_use = 1'b1; #1;
        chk("full_ready", lu_ready, 1'b0);
        chk("full_stall_x9", ds_stall, 1'b1);
        ds_rs2_use = 1'b0; ds_rs1 = 5'd20; ds_rs1_use = 1'b1; #1;
        chk("full_stall_x20", ds_stall, 1'b1);

        // Reset mid-operation drops buffered results and pend bits.
        cyc(); rst = 1'b1; wb(5'd4, 32'h0000_00B4);
        ds_valid = 1'b1; ds_rs2 = 5'd9; ds_rs2_use = 1'b1; #1;
        chk("mrst_we", rf_we, 1'b0);
        chk("mrst_ready", lu_ready, 1'b0);
        chk("mrst_stall", ds_stall, 1'b0);
        chk("mrst_dbg_wen", debug_wb_rf_wen, 4'h0);
        cyc(); rst = 1'b0;
        ds_valid = 1'b1; ds_rs2 = 5'd9; ds_rs2_use = 1'b1; ds_rs1 = 5'd20; ds_rs1_use = 1'b1; #1;
        chk("mrst_after_we", rf_we, 1'b0);
        chk("mrst_after_ready", lu_ready, 1'b1);
        chk("mrst_after_stall", ds_stall, 1'b0);
        chk("mrst_after_cnt", contention_cnt, 16'd0);
        cyc(); #1;
        chk("mrst_after2_we", rf_we, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
